key_bounce_gen: RTL and testbench

//  Generates a mechanical-pushbutton waveform on an active-low key line: press bounce, stable hold, release bounce.

---
 rtl/key_gen_pkg.sv | 20 ++
 rtl/key_lfsr16.sv | 29 ++
 rtl/key_bounce_gen.sv | 148 ++++++++++++++
 tb/tb_key_bounce_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_gen_pkg.sv
// rtl/key_gen_pkg.sv - shared types and LFSR helper for the key bounce generator
package key_gen_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P_BOUNCE = 3'd1,
        HOLD     = 3'd2,
        R_BOUNCE = 3'd3,
        FIN      = 3'd4
    } key_state_e;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic        KEY_IDLE  = 1'b1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/key_lfsr16.sv
// rtl/key_lfsr16.sv - 16-bit Galois LFSR that advances one step per step pulse
module key_lfsr16
    import key_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = step ? lfsr_next(q_q) : q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/key_bounce_gen.sv
// rtl/key_bounce_gen.sv - pushbutton waveform generator; KEY_BOUNCE_GEN_BOUNCE_EN adds press/release bounce
module key_bounce_gen
    import key_gen_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 200000,
    parameter int          SEG_BITS      = 8,
    parameter int          HOLD_W        = 24,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              busy,
    output logic              done,
    output logic              Key
);

    key_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_load;
    logic              key_q, key_d;

    // A hold of 0 behaves like 1: the counter holds cycles-minus-one
    assign hold_load = hold_cycles - HOLD_W'(hold_cycles != '0);

`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    localparam int            BW          = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [BW-1:0] BOUNCE_LOAD = BW'(BOUNCE_CYCLES - 1);

    logic [BW-1:0]       bounce_q, bounce_d;
    logic [SEG_BITS-1:0] seg_q, seg_d;
    logic [15:0]         lfsr_q, lfsr_nx;
    logic                lfsr_step;

    key_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign lfsr_nx = lfsr_next(lfsr_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            key_q    <= KEY_IDLE;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
            bounce_q <= '0;
            seg_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            key_q    <= key_d;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
            bounce_q <= bounce_d;
            seg_q    <= seg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        key_d   = key_q;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
        bounce_d  = bounce_q;
        seg_d     = seg_q;
        lfsr_step = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                key_d = KEY_IDLE;
                if (start) begin
                    hold_d = hold_load;
                    key_d  = ~KEY_IDLE;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
                    state_d  = P_BOUNCE;
                    bounce_d = BOUNCE_LOAD;
                    seg_d    = lfsr_q[SEG_BITS-1:0];
`else
                    state_d  = HOLD;
`endif
                end
            end
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
            P_BOUNCE, R_BOUNCE: begin
                if (seg_q == '0) begin
                    lfsr_step = 1'b1;
                    seg_d     = lfsr_nx[SEG_BITS-1:0];
                    key_d     = ~key_q;
                end else begin
                    seg_d = seg_q - SEG_BITS'(1);
                end
                // End of bounce overrides any toggle from a coinciding segment expiry
                if (bounce_q == '0) begin
                    if (state_q == P_BOUNCE) begin
                        key_d   = ~KEY_IDLE;
                        state_d = HOLD;
                    end else begin
                        key_d   = KEY_IDLE;
                        state_d = FIN;
                    end
                end else begin
                    bounce_d = bounce_q - BW'(1);
                end
            end
`endif
            HOLD: begin
                if (hold_q == '0) begin
                    key_d = KEY_IDLE;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
                    state_d  = R_BOUNCE;
                    bounce_d = BOUNCE_LOAD;
                    seg_d    = lfsr_q[SEG_BITS-1:0];
`else
                    state_d  = FIN;
`endif
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            FIN: begin
                key_d   = KEY_IDLE;
                state_d = IDLE;
            end
            default: begin
                key_d   = KEY_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            P_BOUNCE, HOLD, R_BOUNCE: busy = 1'b1;
            FIN:                      done = 1'b1;
            default:                  ;
        endcase
        Key = key_q;
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb/tb_key_bounce_gen.sv - scoreboard bench for key_bounce_gen (BOUNCE_CYCLES=50, SEG_BITS=3)
module tb_key_bounce_gen;

    localparam int BC     = 50;
    localparam int SB     = 3;
    localparam int HW     = 24;
    localparam int FILT_N = 100;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    localparam int BNC = BC;
`else
    localparam int BNC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [HW-1:0] hold_cycles;
    logic          busy, done, Key;

    always #5 clk = ~clk;

    key_bounce_gen #(
        .BOUNCE_CYCLES (BC),
        .SEG_BITS      (SB),
        .HOLD_W        (HW),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold_cycles (hold_cycles),
        .busy        (busy),
        .done        (done),
        .Key         (Key)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int exp_q[$];
    int rel_flags = 0;
    logic filt = 1'b1;
    int fcnt = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lat(input int h);
        return 2 * BNC + ((h < 1) ? 1 : h) + 1;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest accepted start
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            check("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                check("done_cycle", edge_n, e);
                check("done_key", Key, 1);
            end
        end
    end

    // Reference debounce filter: N consecutive differing samples flip the level
    always @(negedge clk) begin
        if (rst) begin
            filt = 1'b1;
            fcnt = 0;
        end else if (Key === filt) begin
            fcnt = 0;
        end else begin
            fcnt++;
            if (fcnt >= FILT_N) begin
                filt = Key;
                fcnt = 0;
                if (Key === 1'b1) rel_flags++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input bit accept);
        @(negedge clk);
        start       = 1'b1;
        hold_cycles = HW'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (accept) exp_q.push_back(edge_n + lat(h) - 1);
    endtask

`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    logic rec [1:301];
    logic brec[1:301];
    logic p1  [1:50];

    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            rec[k]  = Key;
            brec[k] = busy;
        end
    endtask
`endif

    initial begin
        int bad_k, bad_b, bad_d;
        rst         = 1'b1;
        start       = 1'b0;
        hold_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        bad_k = 0; bad_b = 0; bad_d = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Key !== 1'b1) bad_k++;
            if (busy !== 1'b0) bad_b++;
            if (done !== 1'b0) bad_d++;
        end
        check("idle_key", bad_k, 0);
        check("idle_busy", bad_b, 0);
        check("idle_done", bad_d, 0);

`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
        begin
            int tog, zb, bb, mism;
            pulse(200, 1);
            record(301);
            check("press_edge", rec[1], 0);
            tog = 0;
            for (int k = 2; k <= 50; k++) if (rec[k] !== rec[k-1]) tog++;
            check("press_bounce_toggles", tog > 0, 1);
            zb = 0;
            for (int k = 51; k <= 250; k++) if (rec[k] !== 1'b0) zb++;
            check("hold_low_200", zb, 0);
            check("release_edge", rec[251], 1);
            tog = 0;
            for (int k = 252; k <= 300; k++) if (rec[k] !== rec[k-1]) tog++;
            check("release_bounce_toggles", tog > 0, 1);
            bb = 0;
            for (int k = 1; k <= 300; k++) if (brec[k] !== 1'b1) bb++;
            check("busy_span", bb, 0);
            check("fin_busy", brec[301], 0);
            check("fin_key", rec[301], 1);
            for (int k = 1; k <= 50; k++) p1[k] = rec[k];

            wait_cyc(160);
            check("release_flags_hold200", rel_flags, 1);
            pulse(60, 1);
            wait_cyc(lat(60) + 160);
            check("release_flags_hold60", rel_flags, 1);

            pulse(20, 1);
            wait_cyc(9);
            pulse(7, 0);
            wait_cyc(89);
            pulse(7, 0);
            wait_cyc(20);
            check("in_fin_done", done, 1);
            pulse(7, 0);
            check("idle_after_fin", busy, 0);
            pulse(3, 1);
            check("restart_busy", busy, 1);
            wait_cyc(lat(3) + 5);
            check("queue_drained_t4", exp_q.size(), 0);

            pulse(200, 1);
            wait_cyc(149);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("rst_key", Key, 1);
            check("rst_busy", busy, 0);
            rst = 1'b0;
            exp_q.delete();
            pulse(200, 1);
            record(50);
            mism = 0;
            for (int k = 1; k <= 50; k++) if (rec[k] !== p1[k]) mism++;
            check("replay_pattern", mism, 0);
            wait_cyc(lat(200));
        end
`else
        begin
            int zb;
            pulse(0, 1);
            check("clean_press", Key, 0);
            check("clean_busy", busy, 1);
            wait_cyc(1);
            check("clean_release", Key, 1);
            check("clean_done", done, 1);
            wait_cyc(3);

            pulse(5, 1);
            zb = (Key !== 1'b0) ? 1 : 0;
            wait_cyc(2);
            if (Key !== 1'b0) zb++;
            pulse(9, 0);
            if (Key !== 1'b0) zb++;
            wait_cyc(1);
            if (Key !== 1'b0) zb++;
            check("hold5_low", zb, 0);
            wait_cyc(1);
            check("hold5_fin", done, 1);
            pulse(9, 0);
            check("idle_after_fin", busy, 0);

            pulse(50, 1);
            wait_cyc(10);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("rst_key", Key, 1);
            check("rst_busy", busy, 0);
            rst = 1'b0;
            exp_q.delete();
            pulse(2, 1);
            wait_cyc(10);
        end
`endif
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
